// File: rtl/idli_sqi_pkg.sv
// Shared types and constants for the idli SQI arbiter: FSM state encoding,
// serial command bytes and per-phase nibble counts.
package idli_sqi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 4;
  localparam int DATA_NIBBLES = 4;

  // Counter value of the final nibble in each fixed-length phase
  localparam logic [3:0] CMD_LAST  = 4'(CMD_NIBBLES - 1);
  localparam logic [3:0] ADDR_LAST = 4'(ADDR_NIBBLES - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_NIBBLES - 1);

endpackage

// File: rtl/idli_sqi_shift.sv
// 16-bit nibble shift register. Parallel load has priority over shift; a
// shift moves the top nibble out and brings shift_in into the bottom.
module idli_sqi_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        shift,
  input  logic [3:0]  shift_in,
  output logic [15:0] q
);

  logic [15:0] q_reg;

  // Load or shift one nibble per enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= 16'h0000;
    end else if (load) begin
      q_reg <= load_val;
    end else if (shift) begin
      q_reg <= {q_reg[11:0], shift_in};
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/idli_sqi_arb.sv
// Two-requester (fetch / data) arbiter in front of a quad-SPI memory.
// Round-robin grant, then CMD, ADDR, optional DUMMY and DATA nibble phases at
// two clocks per nibble, and a one-cycle ack in DONE.
// Build option: IDLI_SQI_ARB_WRITE_EN enables store transactions; without it
// data_we is ignored and every data request is a read.
module idli_sqi_arb #(
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_wdata,
  output logic        data_ack,
  output logic [15:0] rdata,
  output logic        sqi_sck,
  output logic        sqi_cs,
  output logic [3:0]  sqi_sio_out,
  output logic [3:0]  sqi_sio_oe,
  input  logic [3:0]  sqi_sio_in
);
  import idli_sqi_pkg::*;

  localparam bit         HAS_DUMMY  = (DUMMY_NIBBLES > 0);
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);

  state_t      state_reg, state_next;
  logic        phase_reg;
  logic [3:0]  cnt_reg;
  logic [15:0] addr_reg, wdata_reg;
  logic        we_reg, gnt_data_reg, last_data_reg;

  logic        any_req, grant_fetch, grant_data, data_we_eff, last_nib, active;
  logic        sh_load, sh_shift;
  logic [15:0] sh_load_val, sh_q;

`ifdef IDLI_SQI_ARB_WRITE_EN
  assign data_we_eff = data_we;
`else
  logic unused_data_we;
  assign unused_data_we = data_we;
  assign data_we_eff    = 1'b0;
`endif

  // Round-robin: on a tie the requester not granted last wins
  always_comb begin
    any_req     = fetch_req | data_req;
    grant_fetch = fetch_req & (~data_req | last_data_reg);
    grant_data  = data_req & ~grant_fetch;
  end

  // Flag the final nibble of the current phase
  always_comb begin
    last_nib = 1'b0;
    case (state_reg)
      CMD:     last_nib = (cnt_reg == CMD_LAST);
      ADDR:    last_nib = (cnt_reg == ADDR_LAST);
      DUMMY:   last_nib = (cnt_reg == DUMMY_LAST);
      DATA:    last_nib = (cnt_reg == DATA_LAST);
      default: last_nib = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: advance at the end of phase 1 of a phase's last nibble
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (any_req) state_next = CMD;
      CMD:   if (phase_reg && last_nib) state_next = ADDR;
      ADDR:  if (phase_reg && last_nib) state_next = (we_reg || !HAS_DUMMY) ? DATA : DUMMY;
      DUMMY: if (phase_reg && last_nib) state_next = DATA;
      DATA:  if (phase_reg && last_nib) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Nibble timing and request latches captured at grant
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg     <= 1'b0;
      cnt_reg       <= 4'd0;
      addr_reg      <= 16'h0000;
      wdata_reg     <= 16'h0000;
      we_reg        <= 1'b0;
      gnt_data_reg  <= 1'b0;
      last_data_reg <= 1'b1;
    end else if (state_reg == IDLE || state_reg == DONE) begin
      phase_reg <= 1'b0;
      cnt_reg   <= 4'd0;
      if (state_reg == IDLE && any_req) begin
        addr_reg      <= grant_data ? data_addr : fetch_addr;
        wdata_reg     <= data_wdata;
        we_reg        <= grant_data & data_we_eff;
        gnt_data_reg  <= grant_data;
        last_data_reg <= grant_data;
      end
    end else begin
      phase_reg <= ~phase_reg;
      if (phase_reg) begin
        cnt_reg <= last_nib ? 4'd0 : cnt_reg + 4'd1;
      end
    end
  end

  // Shift register control: command at grant, then address, then write data
  always_comb begin
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_load_val = 16'h0000;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          sh_load     = 1'b1;
          sh_load_val = {(grant_data && data_we_eff) ? CMD_WRITE : CMD_READ, 8'h00};
        end
      end
      CMD: begin
        if (phase_reg && last_nib) begin
          sh_load     = 1'b1;
          sh_load_val = addr_reg;
        end else begin
          sh_shift = phase_reg;
        end
      end
      ADDR: begin
        if (phase_reg && last_nib && we_reg) begin
          sh_load     = 1'b1;
          sh_load_val = wdata_reg;
        end else begin
          sh_shift = phase_reg;
        end
      end
      DUMMY, DATA: sh_shift = phase_reg;
      default: ;
    endcase
  end

  idli_sqi_shift u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .shift_in (sqi_sio_in),
    .q        (sh_q)
  );

  // FSM outputs: bus pins, acks and read word
  always_comb begin
    active      = (state_reg == CMD) || (state_reg == ADDR) ||
                  (state_reg == DUMMY) || (state_reg == DATA);
    sqi_cs      = ~active;
    sqi_sck     = active & phase_reg;
    sqi_sio_oe  = ((state_reg == CMD) || (state_reg == ADDR) ||
                   ((state_reg == DATA) && we_reg)) ? 4'hF : 4'h0;
    sqi_sio_out = (sqi_sio_oe == 4'hF) ? sh_q[15:12] : 4'h0;
    fetch_ack   = (state_reg == DONE) & ~gnt_data_reg;
    data_ack    = (state_reg == DONE) & gnt_data_reg;
    rdata       = (state_reg == DONE) ? sh_q : 16'h0000;
  end

endmodule

// File: tb/tb_idli_sqi_arb.sv
// Self-checking bench for idli_sqi_arb: quad-SPI memory model on the bus,
// ack scoreboard, table of single transactions and arbitration/reset sequences.
`timescale 1ns/1ps
module tb_idli_sqi_arb;

  localparam int DN     = 2;
  localparam int RD_LAT = 1 + 2 * (10 + DN);
  localparam int WR_LAT = 21;
`ifdef IDLI_SQI_ARB_WRITE_EN
  localparam bit WE_ON = 1'b1;
`else
  localparam bit WE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, data_req, data_we;
  logic [15:0] fetch_addr, data_addr, data_wdata;
  logic        fetch_ack, data_ack;
  logic [15:0] rdata;
  logic        sqi_sck, sqi_cs;
  logic [3:0]  sqi_sio_out, sqi_sio_oe;
  logic [3:0]  sqi_sio_in = 4'h0;

  always #5 clk = ~clk;

  idli_sqi_arb #(.DUMMY_NIBBLES(DN)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_ack    (data_ack),
    .rdata       (rdata),
    .sqi_sck     (sqi_sck),
    .sqi_cs      (sqi_cs),
    .sqi_sio_out (sqi_sio_out),
    .sqi_sio_oe  (sqi_sio_oe),
    .sqi_sio_in  (sqi_sio_in)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- memory model on the SQI bus ----------------
  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] data;
    int          nibs;
    logic        oe_ok;
  } bus_t;

  logic [15:0] mem [logic [15:0]];
  bus_t        bus_q[$];
  bus_t        mon_e;
  int          idx = 0;
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_addr = 16'h0, m_data = 16'h0, m_rd = 16'h0;
  logic        m_oe_ok = 1'b1;
  logic [3:0]  m_exp_oe;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Capture nibbles mid phase 1, present read data mid phase 0
  always @(negedge clk) begin
    if (sqi_cs) begin
      if (idx > 0) begin
        mon_e.cmd   = m_cmd;
        mon_e.addr  = m_addr;
        mon_e.data  = m_data;
        mon_e.nibs  = idx;
        mon_e.oe_ok = m_oe_ok;
        if (m_cmd == 8'h02 && idx == 10) mem[m_addr] = m_data;
        bus_q.push_back(mon_e);
      end
      idx        = 0;
      m_oe_ok    = 1'b1;
      sqi_sio_in = 4'h0;
      if (sqi_sck) begin
        n_fail++;
        $display("FAIL sck_idle: sck %b while cs %b, required sck 0", sqi_sck, sqi_cs);
      end
    end else if (!sqi_sck) begin
      if (idx == 6 + DN) m_rd = mem_rd(m_addr);
      if (m_cmd == 8'h03 && idx >= 6 + DN && idx < 10 + DN)
        sqi_sio_in = m_rd[4*(9+DN-idx) +: 4];
      else
        sqi_sio_in = 4'h0;
    end else begin
      m_exp_oe = (idx < 6 || m_cmd == 8'h02) ? 4'hF : 4'h0;
      if (sqi_sio_oe !== m_exp_oe) m_oe_ok = 1'b0;
      if (idx < 2)              m_cmd  = {m_cmd[3:0], sqi_sio_out};
      else if (idx < 6)         m_addr = {m_addr[11:0], sqi_sio_out};
      else if (m_cmd == 8'h02)  m_data = {m_data[11:0], sqi_sio_out};
      else if (idx >= 6 + DN)   m_data = {m_data[11:0], sqi_sio_in};
      idx++;
    end
  end

  // ---------------- ack scoreboard ----------------
  typedef struct {
    logic        is_fetch;
    logic        chk_rdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   ack_count = 0;

  always @(negedge clk) begin
    if (!rst && (fetch_ack || data_ack)) begin
      ack_count++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_ack: fetch_ack %b data_ack %b, required none", fetch_ack, data_ack);
      end else begin
        sb_e = exp_q.pop_front();
        check("ack_onehot", 32'(fetch_ack & data_ack), 32'd0);
        check("ack_owner_fetch", 32'(fetch_ack), 32'(sb_e.is_fetch));
        if (sb_e.chk_rdata) check("rdata", 32'(rdata), 32'(sb_e.rdata));
      end
    end
  end

  // ---------------- single-transaction vectors ----------------
  typedef struct {
    logic        is_data;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_word;
    int          exp_lat;
    logic        chk_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input string tag);
    int   lat;
    exp_t e;
    bus_t b;
    e.is_fetch  = !v.is_data;
    e.chk_rdata = v.chk_rdata;
    e.rdata     = v.exp_word;
    exp_q.push_back(e);
    @(negedge clk);
    if (v.is_data) begin
      data_req = 1'b1; data_we = v.we; data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      fetch_req = 1'b1; fetch_addr = v.addr;
    end
    lat = 0;
    while (!(fetch_ack || data_ack) && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // inputs changed after grant must not reach the bus
        data_addr = ~v.addr; data_wdata = ~v.wdata; data_we = ~v.we; fetch_addr = ~v.addr;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    fetch_req = 1'b0;
    data_req  = 1'b0;
    @(negedge clk);
    check({tag, "_bus_count"}, 32'(bus_q.size()), 32'd1);
    if (bus_q.size() > 0) begin
      b = bus_q.pop_front();
      check({tag, "_cmd"},   32'(b.cmd),   32'(v.exp_cmd));
      check({tag, "_addr"},  32'(b.addr),  32'(v.addr));
      check({tag, "_data"},  32'(b.data),  32'(v.exp_word));
      check({tag, "_nibs"},  32'(b.nibs),  (v.exp_cmd == 8'h02) ? 32'd10 : 32'(10 + DN));
      check({tag, "_oe"},    32'(b.oe_ok), 32'd1);
      if (v.exp_cmd == 8'h02) check({tag, "_mem"}, 32'(mem_rd(v.addr)), 32'(v.wdata));
    end
  endtask

  // ---------------- round-robin sequence ----------------
  task automatic run_rr();
    exp_t e;
    bus_t b;
    logic [15:0] fa[2];
    logic [15:0] da[2];
    logic [15:0] exp_addr[4];
    fa = '{16'h1234, 16'h0000};
    da = '{16'h00A0, 16'hFFFF};
    exp_addr = '{16'h1234, 16'h00A0, 16'h0000, 16'hFFFF};
    for (int k = 0; k < 2; k++) begin
      e.is_fetch = 1'b1; e.chk_rdata = 1'b1; e.rdata = mem_rd(fa[k]); exp_q.push_back(e);
      e.is_fetch = 1'b0; e.chk_rdata = 1'b1; e.rdata = mem_rd(da[k]); exp_q.push_back(e);
    end
    fork
      begin
        int t;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          fetch_req = 1'b1; fetch_addr = fa[k];
          t = 0;
          while (!fetch_ack && t < 200) begin @(negedge clk); t++; end
          check("rr_fetch_acked", 32'(fetch_ack), 32'd1);
          fetch_req = 1'b0;
        end
      end
      begin
        int t;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          data_req = 1'b1; data_we = 1'b0; data_addr = da[k]; data_wdata = 16'h0;
          t = 0;
          while (!data_ack && t < 200) begin @(negedge clk); t++; end
          check("rr_data_acked", 32'(data_ack), 32'd1);
          data_req = 1'b0;
        end
      end
    join
    @(negedge clk);
    check("rr_bus_count", 32'(bus_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (bus_q.size() > 0) begin
        b = bus_q.pop_front();
        check("rr_order_addr", 32'(b.addr), 32'(exp_addr[k]));
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int acks_before;
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = 16'h0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 16'h0; data_wdata = 16'h0;
    mem[16'h1234] = 16'hBEEF;
    mem[16'h00A0] = 16'h5A5A;
    mem[16'hFFFF] = 16'h0001;
    mem[16'h0000] = 16'hFFFF;
    mem[16'h8001] = 16'h7E81;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 8'h03, 16'hBEEF, RD_LAT, 1'b1};
    if (WE_ON)
      vecs[1] = '{1'b1, 1'b1, 16'h00A0, 16'hC0DE, 8'h02, 16'hC0DE, WR_LAT, 1'b0};
    else
      vecs[1] = '{1'b1, 1'b1, 16'h00A0, 16'hC0DE, 8'h03, 16'h5A5A, RD_LAT, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'h00A0, 16'h0000, 8'h03, WE_ON ? 16'hC0DE : 16'h5A5A, RD_LAT, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 8'h03, 16'h0001, RD_LAT, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 8'h03, 16'hFFFF, RD_LAT, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'h8001, 16'h1111, 8'h03, 16'h7E81, RD_LAT, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_cs",     32'(sqi_cs),      32'd1);
    check("rst_sck",    32'(sqi_sck),     32'd0);
    check("rst_oe",     32'(sqi_sio_oe),  32'd0);
    check("rst_out",    32'(sqi_sio_out), 32'd0);
    check("rst_acks",   32'({fetch_ack, data_ack}), 32'd0);
    check("rst_rdata",  32'(rdata),       32'd0);
    rst = 1'b0;

    run_rr();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // reset in the middle of the ADDR phase aborts without ack
    acks_before = ack_count;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 16'h5678;
    repeat (6) @(negedge clk);
    check("abort_in_addr_cs", 32'(sqi_cs),     32'd0);
    check("abort_in_addr_oe", 32'(sqi_sio_oe), 32'hF);
    rst = 1'b1;
    fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs",  32'(sqi_cs),     32'd1);
    check("abort_sck", 32'(sqi_sck),    32'd0);
    check("abort_oe",  32'(sqi_sio_oe), 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_ack", 32'(ack_count), 32'(acks_before));
    bus_q.delete();

    // recovery: fresh request after the abort is served normally
    run_vec(vecs[0], "post_abort");

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/idli_sqi_arb.md
IDLI_SQI_ARB -- requirements
Module: idli_sqi_arb

Interface
REQ-001 SHALL have parameter DUMMY_NIBBLES, default 2: read dummy nibbles between address and data.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports fetch_req in 1 and fetch_addr in 16: instruction-fetch request and byte address.
REQ-005 SHALL have port fetch_ack  out  1  one-cycle pulse; fetch word valid on rdata.
REQ-006 SHALL have ports data_req in 1, data_we in 1, data_addr in 16, data_wdata in 16: load/store request.
REQ-007 SHALL have port data_ack  out  1  one-cycle pulse; load word valid on rdata, or store complete.
REQ-008 SHALL have port rdata  out  16  read word shared by both requesters; valid only in the ack cycle.
REQ-009 SHALL have ports sqi_sck out 1, sqi_cs out 1 (active-low), sqi_sio_out out 4, sqi_sio_oe out 4, sqi_sio_in in 4.

Function
REQ-010 SHALL use FSM states IDLE, CMD, ADDR, DUMMY, DATA, DONE.
REQ-011 SHALL in IDLE grant one pending request and latch its addr, we and wdata at grant; later changes to the requester's inputs SHALL be ignored.
REQ-012 SHALL round-robin on simultaneous requests: grant the requester not granted last. Single request: grant immediately.
REQ-013 SHALL require requesters to hold req until ack; a req deasserted before grant is dropped without side effect.
REQ-014 SHALL take 2 clk cycles per nibble: phase 0 sck=0 and drive nibble; phase 1 sck=1 and sample sqi_sio_in at end of phase.
REQ-015 SHALL send, MSB nibble first and sio_oe=4'hF:
  - CMD: 2 nibbles, 8'h03 read / 8'h02 write.
  - ADDR: 4 nibbles.
REQ-016 SHALL on read: DUMMY (DUMMY_NIBBLES nibbles, sio_oe=0), then DATA (4 nibbles sampled MSB first, sio_oe=0).
REQ-017 SHALL on write: skip DUMMY; DATA drives 4 wdata nibbles MSB first, sio_oe=4'hF.
REQ-018 SHALL hold sqi_cs=0 from the cycle after grant until the last DATA phase; cs=1 in IDLE and DONE.
REQ-019 SHALL in DONE pulse the granted requester's ack for one cycle, then go to IDLE.
REQ-020 SHALL give latency grant-cycle to ack of 1+2*(10+DUMMY_NIBBLES) cycles on read (25 at default) and 21 on write.
REQ-021 SHALL allow the requester not acked to be granted in the IDLE cycle after DONE; the same requester is blocked for no extra cycle beyond round-robin.
REQ-022 SHALL keep sqi_sck=0 whenever sqi_cs=1.

Reset
REQ-023 SHALL on rst: state=IDLE, sqi_cs=1, sqi_sck=0, sqi_sio_oe=0, sqi_sio_out=0, acks=0, rdata=0, last-grant=data (fetch wins the first tie).
REQ-024 SHALL on rst mid-transaction: abort with no ack, apply REQ-023 values next cycle, and require requesters to re-issue.

Configuration
REQ-025 SHALL use macro IDLI_SQI_ARB_WRITE_EN. Defined: writes per REQ-017. Undefined: data_we ignored; every data request is a read, and no 8'h02 command is ever emitted.

Structure
REQ-026 SHALL place the state enum, the command constants (8'h03, 8'h02) and the nibble-count constants in package idli_sqi_pkg.
REQ-027 SHALL use one sub-module, idli_sqi_shift: 16-bit nibble shift register with load, shift-out and shift-in.

Verification
REQ-028 SHALL cover: fetch_req, addr 16'h1234; memory model returns 16'hBEEF -> cmd 03, addr nibbles 1,2,3,4; fetch_ack 25 cycles after grant with rdata=16'hBEEF.
REQ-029 SHALL cover: data write, addr 16'h00A0, wdata 16'hC0DE -> nibbles 0,2,0,0,A,0,C,0,D,E; data_ack at 21 cycles; model holds C0DE.
REQ-030 SHALL cover: fetch and data requested on the same cycle after reset, both held -> fetch served first, then data; repeat both -> alternate strictly.
REQ-031 SHALL cover: rst asserted in ADDR phase -> next cycle cs=1, sck=0, oe=0; no ack ever emitted for that request.
REQ-032 SHALL cover: IDLI_SQI_ARB_WRITE_EN undefined, data_we=1 -> read command 03 issued; data_ack with read data.
REQ-033 SHALL cover: data_addr changed after grant -> bus still shows the latched address.
